// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory port between N_REQ requesters.
// Each access takes three cycles: arbitrate (IDLE), grant/read (GRANT), return data (DATA).
module mem_arbiter #(
  parameter int N_REQ = 4,
  parameter int AW    = 14,
  parameter int DW    = 10,
  parameter int CW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*AW-1:0]        addr,
  output logic [N_REQ-1:0]           grant,
  output logic [DW-1:0]              rdata,
  output logic [N_REQ-1:0]           rvalid,
  output logic                       mem_en,
  output logic [AW-1:0]              mem_addr,
  input  logic [DW-1:0]              mem_rdata,
  input  logic [$clog2(N_REQ)-1:0]   dbg_sel,
  output logic [1:0]                 D_STATE,
  output logic [$clog2(N_REQ)-1:0]   D_LAST,
  output logic [CW-1:0]              D_COUNT
);

  localparam int SW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] win, win_nxt, last;
  logic          found;
  logic [CW-1:0] cnt [N_REQ];

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Rotating priority: search starts just after the last winner and ends on it.
  always_comb begin
    found   = 1'b0;
    win_nxt = last;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req[(int'(last) + k) % N_REQ]) begin
        found   = 1'b1;
        win_nxt = SW'((int'(last) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   state_nxt = DATA;
      DATA:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win      <= '0;
      last     <= SW'(N_REQ - 1);
      mem_addr <= '0;
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      if (state == IDLE && found) begin
        win      <= win_nxt;
        mem_addr <= addr[int'(win_nxt)*AW +: AW];
      end
      if (state == GRANT) begin
        last     <= win;
        cnt[win] <= sat_inc(cnt[win]);
      end
    end
  end

  // Outputs decode from registered state only, so req never reaches grant combinationally.
  always_comb begin
    grant  = '0;
    rvalid = '0;
    if (state == GRANT) grant[win]  = 1'b1;
    if (state == DATA)  rvalid[win] = 1'b1;
  end

  assign mem_en  = (state == GRANT);
  assign rdata   = (state == DATA) ? mem_rdata : '0;
  assign D_STATE = state;
  assign D_LAST  = last;

  always_comb begin
    D_COUNT = '0;
    if (int'(dbg_sel) < N_REQ) D_COUNT = cnt[dbg_sel];
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed vectors push expected grant/data events,
// a negedge monitor pops and compares them; a DMA phase checks data against a memory model.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 14;
  localparam int DW = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]  grant, rvalid;
  logic [DW-1:0] rdata, mem_rdata;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [1:0]    dbg_sel;
  logic [1:0]    D_STATE;
  logic [1:0]    D_LAST;
  logic [CW-1:0] D_COUNT;

  logic [N-1:0]  s_grant, s_rvalid;
  logic [DW-1:0] s_rdata;
  logic          s_mem_en;
  logic [AW-1:0] s_mem_addr;
  logic [1:0]    s_state, s_last;
  logic [1:0]    s_count;

  logic [N-1:0]  req_main;
  logic [AW-1:0] addr_main [N];
  logic          dma_req  [3];
  logic [AW-1:0] dma_addr [3];
  logic          dma_mode;
  logic          sb_on;
  int            dma_cnt [3];
  int            cyc = 0;
  int            dma_end;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct { logic [N-1:0] g; logic [AW-1:0] a; } gexp_t;
  typedef struct { logic [N-1:0] v; logic [DW-1:0] d; } dexp_t;
  gexp_t gq[$];
  dexp_t dq[$];
  gexp_t ge;
  dexp_t de;

  logic [N-1:0] t2_g [12] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000,
                              4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};

  mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .grant(grant), .rdata(rdata),
    .rvalid(rvalid), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dbg_sel(dbg_sel), .D_STATE(D_STATE), .D_LAST(D_LAST), .D_COUNT(D_COUNT)
  );

  // Narrow-counter instance exposes saturation within a short run.
  mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .CW(2)) u_sat (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .grant(s_grant), .rdata(s_rdata),
    .rvalid(s_rvalid), .mem_en(s_mem_en), .mem_addr(s_mem_addr), .mem_rdata(mem_rdata),
    .dbg_sel(dbg_sel), .D_STATE(s_state), .D_LAST(s_last), .D_COUNT(s_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return a[9:0] ^ 10'h386 ^ {6'd0, a[13:10]};
  endfunction

  always @(posedge clk) if (mem_en) mem_rdata <= memf(mem_addr);

  always_comb begin
    addr = '0;
    for (int i = 0; i < N; i++)
      addr[i*AW +: AW] = (dma_mode && i < 3) ? dma_addr[i] : addr_main[i];
    req = req_main | {1'b0, dma_req[2], dma_req[1], dma_req[0]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (grant != '0) begin
      chk("grant_onehot", 32'($onehot(grant)), 1);
      if (sb_on) begin
        if (gq.size() == 0) chk("unexpected_grant", 32'(grant), 0);
        else begin
          ge = gq.pop_front();
          chk("sb_grant", 32'(grant), 32'(ge.g));
          chk("sb_mem_en", 32'(mem_en), 1);
          chk("sb_mem_addr", 32'(mem_addr), 32'(ge.a));
        end
      end
    end else if (mem_en) chk("stray_mem_en", 32'(mem_en), 0);
    if (rvalid != '0 && sb_on) begin
      if (dq.size() == 0) chk("unexpected_rvalid", 32'(rvalid), 0);
      else begin
        de = dq.pop_front();
        chk("sb_rvalid", 32'(rvalid), 32'(de.v));
        chk("sb_rdata", 32'(rdata), 32'(de.d));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic push(input logic [N-1:0] g, input logic [AW-1:0] a, input logic [DW-1:0] d);
    gq.push_back('{g: g, a: a});
    dq.push_back('{v: g, d: d});
  endtask

  task automatic dma(input int id, input logic [AW-1:0] seed);
    logic [AW-1:0] lf;
    logic [DW-1:0] expd;
    int w;
    lf = seed;
    while (cyc < dma_end) begin
      dma_addr[id] = lf;
      dma_req[id]  = 1'b1;
      w = 0;
      do begin @(negedge clk); w++; end while (!grant[id] && w < 30);
      if (!grant[id]) begin
        chk("dma_grant_timeout", 0, 1);
        dma_req[id] = 1'b0;
        return;
      end
      expd = memf(lf);
      dma_req[id] = 1'b0;
      @(negedge clk);
      chk("dma_rvalid", 32'(rvalid[id]), 1);
      chk("dma_rdata", 32'(rdata), 32'(expd));
      dma_cnt[id]++;
      lf = {lf[12:0], lf[13] ^ lf[12] ^ lf[11] ^ lf[1]};
      repeat (id) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_main = '0; dbg_sel = '0; dma_mode = 1'b0; sb_on = 1'b1;
    mem_rdata = '0;
    for (int i = 0; i < N; i++) addr_main[i] = '0;
    for (int i = 0; i < 3; i++) begin dma_req[i] = 1'b0; dma_addr[i] = '0; dma_cnt[i] = 0; end
    tick(2);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_state", 32'(D_STATE), 0);
    chk("rst_last", 32'(D_LAST), 3);
    rst = 1'b0;
    tick(1);

    // single access from requester 0
    addr_main[0] = 14'h0123; req_main = 4'b0001;
    push(4'b0001, 14'h0123, 10'h2A5);
    chk("t1_state_idle", 32'(D_STATE), 0);
    tick(1); chk("t1_state_grant", 32'(D_STATE), 1); req_main = '0;
    tick(1); chk("t1_state_data", 32'(D_STATE), 2);
    tick(1); chk("t1_state_back", 32'(D_STATE), 0);
    dbg_sel = 2'd0; #1;
    chk("t1_count0", 32'(D_COUNT), 1);
    chk("t1_last", 32'(D_LAST), 0);

    // all four requesting: strict rotation from requester 0
    reset_dut();
    addr_main[0] = 14'h0011; addr_main[1] = 14'h0222;
    addr_main[2] = 14'h0333; addr_main[3] = 14'h3FFF;
    push(4'b0001, 14'h0011, 10'h397);
    push(4'b0010, 14'h0222, 10'h1A4);
    push(4'b0100, 14'h0333, 10'h0B5);
    push(4'b1000, 14'h3FFF, 10'h076);
    req_main = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      chk($sformatf("t2_grant_c%0d", c + 1), 32'(grant), 32'(t2_g[c]));
    end
    req_main = '0;
    chk("t2_last", 32'(D_LAST), 3);

    // last=1, req=1001: requester 3 precedes requester 0
    reset_dut();
    addr_main[1] = 14'h0044;
    push(4'b0010, 14'h0044, 10'h3C2);
    req_main = 4'b0010;
    tick(1); req_main = '0;
    tick(2);
    chk("t3_last1", 32'(D_LAST), 1);
    addr_main[3] = 14'h2005; addr_main[0] = 14'h0100;
    push(4'b1000, 14'h2005, 10'h38B);
    push(4'b0001, 14'h0100, 10'h286);
    req_main = 4'b1001;
    tick(1); chk("t3_first", 32'(grant), 32'(4'b1000));
    tick(3); chk("t3_second", 32'(grant), 32'(4'b0001));
    req_main = '0;
    tick(2);
    chk("t3_last0", 32'(D_LAST), 0);

    // req[2] pulse that never spans an IDLE sampling edge
    req_main = 4'b0100;
    @(negedge clk);
    req_main = '0;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      chk("t4_state", 32'(D_STATE), 0);
      chk("t4_mem_en", 32'(mem_en), 0);
      chk("t4_grant", 32'(grant), 0);
    end

    // asynchronous reset while in GRANT
    addr_main[0] = 14'h0077; req_main = 4'b0001;
    tick(1);
    chk("t5_grant_before", 32'(grant), 32'(4'b0001));
    req_main = '0;
    #1 rst = 1'b1;
    #1;
    chk("t5_grant", 32'(grant), 0);
    chk("t5_mem_en", 32'(mem_en), 0);
    chk("t5_rvalid", 32'(rvalid), 0);
    chk("t5_state", 32'(D_STATE), 0);
    chk("t5_last", 32'(D_LAST), 3);
    for (int i = 0; i < N; i++) begin
      dbg_sel = 2'(i); #1;
      chk($sformatf("t5_count%0d", i), 32'(D_COUNT), 0);
    end
    #1 rst = 1'b0;
    tick(1);

    // counter saturation on the 2-bit instance, free count on the wide one
    dbg_sel = 2'd1;
    addr_main[1] = 14'h0044;
    for (int i = 0; i < 5; i++) push(4'b0010, 14'h0044, 10'h3C2);
    req_main = 4'b0010;
    tick(9);
    chk("t6_sat_at_max", 32'(s_count), 3);
    chk("t6_count3", 32'(D_COUNT), 3);
    tick(4);
    req_main = '0;
    tick(2);
    chk("t6_sat_no_wrap", 32'(s_count), 3);
    chk("t6_count5", 32'(D_COUNT), 5);

    // three DMA engines with LFSR addresses against the memory model
    reset_dut();
    sb_on = 1'b0; dma_mode = 1'b1;
    dma_end = cyc + 1000;
    fork
      dma(0, 14'h1ACE);
      dma(1, 14'h0BEE);
      dma(2, 14'h3001);
    join
    tick(3);
    dma_mode = 1'b0; sb_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dbg_sel = 2'(i); #1;
      chk($sformatf("t7_count%0d", i), 32'(D_COUNT), 32'(dma_cnt[i]));
    end
    dbg_sel = 2'd3; #1;
    chk("t7_count3", 32'(D_COUNT), 0);

    chk("sb_grant_queue_empty", 32'(gq.size()), 0);
    chk("sb_data_queue_empty", 32'(dq.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
